nios2_debug_cmd_dispatch: RTL

NIOS2_DEBUG_CMD_DISPATCH -- requirements
Module: nios2_debug_cmd_dispatch

---
 rtl/nios2_debug_cmd_dispatch.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/nios2_debug_cmd_dispatch.sv
// Virtual-JTAG debug command dispatcher: captures IR/DR updates into an in-order
// command queue and issues each command as a one-cycle per-channel strobe.
module nios2_debug_cmd_dispatch #(
  parameter int IR_W       = 2,
  parameter int DR_W       = 38,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [IR_W-1:0]               ir_in,
  input  logic [DR_W-1:0]               sr,
  input  logic                          vs_uir_d1,
  input  logic                          vs_e1dr_d1,
  input  logic [(2**IR_W)-1:0]          ch_ready,
  input  logic                          ovf_clr,
  output logic [DR_W-1:0]               jdo,
  output logic [(2**IR_W)-1:0]          take_action,
  output logic [(2**IR_W)-1:0]          take_no_action,
  output logic [IR_W-1:0]               ir_latched,
  output logic                          cmd_pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int NUM_CH = 2**IR_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int EW     = IR_W + DR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  logic              uir_q, e1dr_q;
  logic              uir_arm, e1dr_arm;
  logic              uir_rise, e1dr_rise;
  logic [IR_W-1:0]   push_ir;
  logic              full, pop, push_ok, drop;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [EW-1:0]     head;
  logic [IR_W-1:0]   head_ir;
  logic [DR_W-1:0]   head_sr;
  logic              head_ready;
  logic [1:0]        state, state_n;
  logic              go_issue;
  logic [NUM_CH-1:0] act_n, noact_n;

  // Arm bits keep a level that is already high out of reset from counting as an edge.
  assign uir_rise  = vs_uir_d1  & ~uir_q  & uir_arm;
  assign e1dr_rise = vs_e1dr_d1 & ~e1dr_q & e1dr_arm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_q    <= 1'b0;
      e1dr_q   <= 1'b0;
      uir_arm  <= 1'b0;
      e1dr_arm <= 1'b0;
    end else begin
      uir_q  <= vs_uir_d1;
      e1dr_q <= vs_e1dr_d1;
      if (!vs_uir_d1)  uir_arm  <= 1'b1;
      if (!vs_e1dr_d1) e1dr_arm <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      ir_latched <= '0;
    else if (uir_rise) ir_latched <= ir_in;
  end

  // A same-cycle update-IR must tag the pushed entry with the new IR.
  assign push_ir = uir_rise ? ir_in : ir_latched;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign pop     = (state == S_ISSUE);
  assign push_ok = e1dr_rise & (~full | pop);
  assign drop    = e1dr_rise & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {push_ir, sr};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  assign fifo_level  = level;
  assign cmd_pending = (level != '0);

  assign head       = mem[rd_ptr];
  assign head_ir    = head[EW-1 -: IR_W];
  assign head_sr    = head[DR_W-1:0];
  assign head_ready = ch_ready[head_ir];

  always_comb begin
    state_n  = state;
    go_issue = 1'b0;
    case (state)
      S_IDLE: begin
        if (level != '0) begin
          go_issue = head_ready;
          state_n  = head_ready ? S_ISSUE : S_STALL;
        end
      end
      S_STALL: begin
        if (head_ready) begin
          go_issue = 1'b1;
          state_n  = S_ISSUE;
        end
      end
      S_ISSUE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    act_n   = '0;
    noact_n = '0;
    if (head_sr[DR_W-1]) act_n[head_ir]   = 1'b1;
    else                 noact_n[head_ir] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Strobes and payload are registered on ISSUE entry so they coincide with the ISSUE state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else if (go_issue) begin
      jdo            <= head_sr;
      take_action    <= act_n;
      take_no_action <= noact_n;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
    end
  end

endmodule
